// File: rtl/ring_buffer_reader.sv
// Read-side controller for a circular sample buffer: tracks occupancy from writer
// advance pulses, fetches words at its own read pointer and hands them downstream.
module ring_buffer_reader #(
    parameter int BufferWidth = 2,
    parameter int DataWidth   = 8
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   sclr,
    input  logic                   wr_en,
    output logic [BufferWidth-1:0] rd_addr,
    output logic                   rd_ren,
    input  logic [DataWidth-1:0]   mem_rdata,
    output logic [DataWidth-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BufferWidth:0]   count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);

    // state | meaning
    // IDLE  | nothing presented; issue a read as soon as a word is buffered
    // READ  | RAM read in flight; capture mem_rdata at the end of this cycle
    // HOLD  | out_data presented with out_valid until out_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [BufferWidth:0] DEPTH = {1'b1, {BufferWidth{1'b0}}};

    logic [1:0]             state;
    logic [BufferWidth-1:0] rptr;
    logic                   issue;
    logic                   wr_acc;
    logic [BufferWidth:0]   count_nxt;

    assign rd_addr = rptr;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign rd_ren  = issue;
    assign wr_acc  = wr_en && !full && !sclr;

    // aclr is folded in so the RAM sees no read strobe while reset is held
    always_comb begin
        issue = 1'b0;
        if (!aclr && !sclr) begin
            case (state)
                IDLE:    issue = !empty;
                HOLD:    issue = out_ready && !empty;
                default: issue = 1'b0;
            endcase
        end
    end

    always_comb begin
        count_nxt = count;
        case ({wr_acc, issue})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (sclr) begin
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (issue)
                rptr <= rptr + 1'b1;
            // a write into a full buffer overwrites an unread slot
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (sclr) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (issue)
                        state <= READ;
                end
                READ: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= issue ? READ : IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
